// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit for the multicycle RV32I core.
//
// Turns byte, halfword and word loads/stores into accesses on a single-port
// word memory with combinational read and synchronous write. Loads are
// extracted and sign/zero-extended. Sub-word stores use read-modify-write.
// Misaligned, out-of-range and illegal-funct3 requests are rejected without
// touching memory.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake; a request is accepted in IDLE
//   req_we, req_funct3     store flag and RV32I funct3
//   req_addr, req_wdata    byte address and store data
//   resp_valid             one-cycle completion pulse
//   resp_err, resp_rdata   rejection flag and extended load data (held)
//   mem_we, mem_a, mem_wd  memory write enable, word address, write data
//   mem_rd                 memory read data (combinational from mem_a)
module lsu_ctrl #(
    parameter int Width    = 32,
    parameter int AddrBits = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [Width-1:0]    req_wdata,
    output logic                resp_valid,
    output logic                resp_err,
    output logic [Width-1:0]    resp_rdata,
    output logic                mem_we,
    output logic [AddrBits-1:0] mem_a,
    output logic [Width-1:0]    mem_wd,
    input  logic [Width-1:0]    mem_rd
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    state_t state, state_next;

    // Latched request. Only the address bits that pick the word and the
    // byte lane are kept; the upper bits are fully consumed by the range
    // check at accept time.
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [AddrBits+1:0] addr_q;
    logic [Width-1:0]    wdata_q;
    logic [Width-1:0]    old_q;
    logic [Width-1:0]    rdata_q;
    logic                err_q;

    logic                f3_legal;
    logic                misaligned;
    logic                out_of_range;
    logic                req_err;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [Width-1:0]    load_data;
    logic [Width-1:0]    merged;

    // Classify the incoming request so an illegal access can skip memory
    // entirely. funct3[1:0] gives the access size for both loads and stores.
    always_comb begin
        f3_legal     = 1'b0;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        if (req_we) begin
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        end else begin
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                       (req_funct3 == 3'b101);
        end
        if (req_funct3[1:0] == 2'b01) begin
            misaligned = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misaligned = |req_addr[1:0];
        end
        out_of_range = |(req_addr >> (AddrBits + 2));
        req_err = !f3_legal || misaligned || out_of_range;
    end

    // Lane extraction for loads and lane insertion for sub-word stores.
    always_comb begin
        byte_sel  = 8'(mem_rd >> {addr_q[1:0], 3'b000});
        half_sel  = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        load_data = mem_rd;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_rd;
        endcase

        merged = wdata_q;
        case (funct3_q)
            3'b000:  begin
                merged = old_q;
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            3'b001:  begin
                merged = old_q;
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    // Next-state logic and the state-decoded outputs. mem_we is decoded
    // from state so that reset drops it immediately.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        mem_a      = addr_q[AddrBits+1:2];
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                mem_a     = '0;
                if (req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (!req_we) begin
                        state_next = LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        state_next = WRITE;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            LOAD:    state_next = RESP;
            RMW_RD:  state_next = WRITE;
            WRITE: begin
                mem_we     = 1'b1;
                mem_wd     = merged;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus request/response holding registers. Response
    // fields are cleared at accept and then hold until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            old_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr[AddrBits+1:0];
                        wdata_q  <= req_wdata;
                        rdata_q  <= '0;
                        err_q    <= req_err;
                    end
                end
                LOAD:    rdata_q <= load_data;
                RMW_RD:  old_q   <= mem_rd;
                default: ;
            endcase
        end
    end

    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

    // The store flag is only needed for routing at accept; keep it latched
    // for debug visibility without feeding any logic.
    logic unused_we;
    assign unused_we = we_q;

endmodule
